// File: rtl/dram_pkg.sv
// Shared DRAM types and address decode, used by the command issuer and the scheduler queue.
package dram_pkg;

  typedef enum logic [2:0] {NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4} cmd_e;
  typedef enum logic [1:0] {READ = 2'd0, WRITE = 2'd1, IFETCH = 2'd2} op_e;

  localparam logic [1:0] OP_ILLEGAL = 2'd3;
  localparam int ADDR_W = 34;

  localparam int COL_LO_LSB = 2;
  localparam int COL_LO_W   = 4;
  localparam int CH_BIT     = 6;
  localparam int BG_LSB     = 7;
  localparam int BANK_LSB   = 10;
  localparam int COL_HI_LSB = 12;
  localparam int COL_HI_W   = 6;
  localparam int ROW_LSB    = 18;

  typedef struct packed {
    logic        channel;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
  } dram_addr_s;

  // Byte offset [1:0] is dropped; column is split around channel/bg/bank.
  function automatic dram_addr_s decode_addr(input logic [ADDR_W-1:0] a);
    dram_addr_s d;
    d.channel = a[CH_BIT];
    d.bg      = a[BG_LSB +: 3];
    d.bank    = a[BANK_LSB +: 2];
    d.row     = a[ROW_LSB +: 16];
    d.col     = {a[COL_HI_LSB +: COL_HI_W], a[COL_LO_LSB +: COL_LO_W]};
    return d;
  endfunction

endpackage

// File: rtl/dram_timing_ctr.sv
// Loadable 8-bit down-counter; saturates at zero and flags it.
module dram_timing_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 count <= 8'd0;
    else if (load)           count <= load_val;
    else if (count != 8'd0)  count <= count - 8'd1;
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/dram_cmd_issuer.sv
// Closed-page DDR5 command issuer: ACT -> RD/WR -> PRE per request, then one-cycle response.
// Optional CMD_LOG_EN adds a cycle counter and a per-command/response log.
module dram_cmd_issuer
  import dram_pkg::*;
#(
  parameter int TRCD   = 39,
  parameter int TCL    = 40,
  parameter int TCWL   = 38,
  parameter int TBURST = 8,
  parameter int TRAS   = 76,
  parameter int TRP    = 39
) (
  input  logic        dimm_clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [33:0] req_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic        cmd_phase,
  output logic        cmd_channel,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        resp_valid,
  output logic [1:0]  resp_op,
  output logic [33:0] resp_addr,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_DATA, S_PRE, S_WAIT_RP, S_RESP
  } state_e;

  // A wait state lasting W cycles loads W-1; two-cycle commands eat into the window.
  localparam logic [7:0] RCD_LD = 8'(TRCD - 3);
  localparam logic [7:0] RD_LD  = 8'(TCL + TBURST - 3);
  localparam logic [7:0] WR_LD  = 8'(TCWL + TBURST - 3);
  localparam logic [7:0] RP_LD  = 8'(TRP - 2);
  localparam logic [7:0] RAS_LD = 8'(TRAS - 1);

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [1:0]  op_q;
  logic [33:0] addr_q;
  dram_addr_s  dec_q;
  logic        accept;
  logic        seq_load, seq_zero, ras_zero;
  logic [7:0]  seq_val;
  cmd_e        cmd_sel;

  assign accept = req_valid && req_ready;

  dram_timing_ctr u_seq_ctr (
    .clk(dimm_clock), .rst(reset), .load(seq_load), .load_val(seq_val), .zero(seq_zero)
  );

  // tRAS runs from ACT phase 0 alongside the RCD/CAS/data waits.
  dram_timing_ctr u_ras_ctr (
    .clk(dimm_clock), .rst(reset), .load(accept), .load_val(RAS_LD), .zero(ras_zero)
  );

  always_ff @(posedge dimm_clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Illegal requests never reach the command bus, so they leave the address fields alone.
  always_ff @(posedge dimm_clock or posedge reset) begin
    if (reset) begin
      op_q   <= 2'd0;
      addr_q <= '0;
      dec_q  <= '0;
    end else if (accept) begin
      op_q   <= req_op;
      addr_q <= req_addr;
      if (req_op != OP_ILLEGAL) dec_q <= decode_addr(req_addr);
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = 1'b0;
    seq_load = 1'b0;
    seq_val  = RCD_LD;
    case (state_q)
      S_IDLE:      if (accept) state_d = (req_op == OP_ILLEGAL) ? S_RESP : S_ACT;
      S_ACT: begin
        if (!phase_q) phase_d = 1'b1;
        else begin
          state_d  = S_WAIT_RCD;
          seq_load = 1'b1;
          seq_val  = RCD_LD;
        end
      end
      S_WAIT_RCD:  if (seq_zero) state_d = S_CAS;
      S_CAS: begin
        if (!phase_q) phase_d = 1'b1;
        else begin
          state_d  = S_WAIT_DATA;
          seq_load = 1'b1;
          seq_val  = (op_q == WRITE) ? WR_LD : RD_LD;
        end
      end
      S_WAIT_DATA: if (seq_zero && ras_zero) state_d = S_PRE;
      S_PRE: begin
        state_d  = S_WAIT_RP;
        seq_load = 1'b1;
        seq_val  = RP_LD;
      end
      S_WAIT_RP:   if (seq_zero) state_d = S_RESP;
      S_RESP:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = 1'b0;
    cmd_sel   = NOP;
    cmd_phase = 1'b0;
    case (state_q)
      S_ACT: begin
        cmd_valid = 1'b1;
        cmd_sel   = ACT;
        cmd_phase = phase_q;
      end
      S_CAS: begin
        cmd_valid = 1'b1;
        cmd_sel   = (op_q == WRITE) ? WR : RD;
        cmd_phase = phase_q;
      end
      S_PRE: begin
        cmd_valid = 1'b1;
        cmd_sel   = PRE;
      end
      default: ;
    endcase
  end

  assign cmd_code    = cmd_sel;
  assign cmd_channel = dec_q.channel;
  assign cmd_bg      = dec_q.bg;
  assign cmd_bank    = dec_q.bank;
  assign cmd_row     = dec_q.row;
  assign cmd_col     = dec_q.col;
  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_err    = resp_valid && (op_q == OP_ILLEGAL);
  assign resp_op     = resp_valid ? op_q : 2'd0;
  assign resp_addr   = resp_valid ? addr_q : 34'd0;

`ifdef CMD_LOG_EN
  logic [63:0] cycle_q;

  always_ff @(posedge dimm_clock or posedge reset) begin
    if (reset) cycle_q <= 64'd0;
    else begin
      cycle_q <= cycle_q + 64'd1;
      if (cmd_valid && !cmd_phase)
        $display("%0d CH%0d %s BG%0d BA%0d R%0h C%0h", cycle_q, cmd_channel,
                 cmd_sel.name(), cmd_bg, cmd_bank, cmd_row, cmd_col);
      if (resp_valid)
        $display("%0d DONE op%0d addr %0h err%0d", cycle_q, resp_op, resp_addr, resp_err);
    end
  end
`endif

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// Directed bench: default-timing instance plus a TRAS=100 instance for the tRAS-bound case.
module tb_dram_cmd_issuer;

  logic        dimm_clock, reset;
  logic        req_valid_a, req_valid_b;
  logic [1:0]  req_op;
  logic [33:0] req_addr;

  logic        a_req_ready, a_cmd_valid, a_cmd_phase, a_cmd_channel, a_resp_valid, a_resp_err, a_busy;
  logic [2:0]  a_cmd_code, a_cmd_bg;
  logic [1:0]  a_cmd_bank, a_resp_op;
  logic [15:0] a_cmd_row;
  logic [9:0]  a_cmd_col;
  logic [33:0] a_resp_addr;

  logic        b_req_ready, b_cmd_valid, b_cmd_phase, b_cmd_channel, b_resp_valid, b_resp_err, b_busy;
  logic [2:0]  b_cmd_code, b_cmd_bg;
  logic [1:0]  b_cmd_bank, b_resp_op;
  logic [15:0] b_cmd_row;
  logic [9:0]  b_cmd_col;
  logic [33:0] b_resp_addr;

  dram_cmd_issuer u_dut_a (
    .dimm_clock(dimm_clock), .reset(reset), .req_valid(req_valid_a), .req_ready(a_req_ready),
    .req_op(req_op), .req_addr(req_addr), .cmd_valid(a_cmd_valid), .cmd_code(a_cmd_code),
    .cmd_phase(a_cmd_phase), .cmd_channel(a_cmd_channel), .cmd_bg(a_cmd_bg), .cmd_bank(a_cmd_bank),
    .cmd_row(a_cmd_row), .cmd_col(a_cmd_col), .resp_valid(a_resp_valid), .resp_op(a_resp_op),
    .resp_addr(a_resp_addr), .resp_err(a_resp_err), .busy(a_busy)
  );

  dram_cmd_issuer #(.TRAS(100)) u_dut_b (
    .dimm_clock(dimm_clock), .reset(reset), .req_valid(req_valid_b), .req_ready(b_req_ready),
    .req_op(req_op), .req_addr(req_addr), .cmd_valid(b_cmd_valid), .cmd_code(b_cmd_code),
    .cmd_phase(b_cmd_phase), .cmd_channel(b_cmd_channel), .cmd_bg(b_cmd_bg), .cmd_bank(b_cmd_bank),
    .cmd_row(b_cmd_row), .cmd_col(b_cmd_col), .resp_valid(b_resp_valid), .resp_op(b_resp_op),
    .resp_addr(b_resp_addr), .resp_err(b_resp_err), .busy(b_busy)
  );

  logic        sel;
  logic        m_cmd_valid, m_cmd_phase, m_resp_valid, m_resp_err, m_ready;
  logic [2:0]  m_cmd_code;
  logic [1:0]  m_resp_op;
  logic [33:0] m_resp_addr;

  assign m_cmd_valid  = sel ? b_cmd_valid  : a_cmd_valid;
  assign m_cmd_phase  = sel ? b_cmd_phase  : a_cmd_phase;
  assign m_cmd_code   = sel ? b_cmd_code   : a_cmd_code;
  assign m_resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign m_resp_err   = sel ? b_resp_err   : a_resp_err;
  assign m_resp_op    = sel ? b_resp_op    : a_resp_op;
  assign m_resp_addr  = sel ? b_resp_addr  : a_resp_addr;
  assign m_ready      = sel ? b_req_ready  : a_req_ready;

  localparam logic [33:0] ADDR1 = 34'h0_1234_5678;
  localparam logic [33:0] ADDR2 = 34'h2_0000_0000;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int t_act, t_cas, t_pre, t_resp, t_rdy, n_valid, t_act2, n_act;
  logic        r_err, rdy_early;
  logic [1:0]  r_op;
  logic [2:0]  cas_code;
  logic [33:0] r_addr;

  initial dimm_clock = 1'b0;
  always #5 dimm_clock = ~dimm_clock;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish before 300000");
    $fatal(1);
  end

  task automatic step();
    @(posedge dimm_clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request at cycle 0 and log when each phase-0 command and the response appear.
  task automatic run_req(input logic use_b, input logic [1:0] op, input logic [33:0] addr);
    sel = use_b;
    req_op = op;
    req_addr = addr;
    if (use_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    t_act = -1; t_cas = -1; t_pre = -1; t_resp = -1; t_rdy = -1;
    n_valid = 0; rdy_early = 1'b0; r_err = 1'b0; r_op = 2'd0; r_addr = '0; cas_code = 3'd0;
    cyc = 0;
    step();
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    while (t_rdy < 0 && cyc < 400) begin
      if (m_cmd_valid) begin
        n_valid++;
        if (!m_cmd_phase) begin
          case (m_cmd_code)
            3'd1:       t_act = cyc;
            3'd2, 3'd3: begin t_cas = cyc; cas_code = m_cmd_code; end
            3'd4:       t_pre = cyc;
            default: ;
          endcase
        end
      end
      if (m_resp_valid) begin
        t_resp = cyc; r_err = m_resp_err; r_op = m_resp_op; r_addr = m_resp_addr;
      end
      if (m_ready) begin
        if (t_resp < 0) rdy_early = 1'b1;
        else t_rdy = cyc;
      end
      if (t_rdy < 0) step();
    end
  endtask

  initial begin
    reset = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0; sel = 1'b0;
    req_op = 2'd0; req_addr = '0;
    #3;
    chk("rst_ready",  a_req_ready, 1);
    chk("rst_cvalid", a_cmd_valid, 0);
    chk("rst_code",   a_cmd_code, 0);
    chk("rst_busy",   a_busy, 0);
    chk("rst_resp",   a_resp_valid, 0);
    chk("rst_row",    a_cmd_row, 0);
    @(posedge dimm_clock); #1;
    reset = 1'b0;

    // Read: ACT 1-2, RD 40-41, PRE 88 (data bound), response 127.
    run_req(1'b0, 2'd0, ADDR1);
    chk("rd_act",   t_act, 1);
    chk("rd_cas",   t_cas, 40);
    chk("rd_code",  cas_code, 2);
    chk("rd_pre",   t_pre, 88);
    chk("rd_resp",  t_resp, 127);
    chk("rd_rdy",   t_rdy, 128);
    chk("rd_nval",  n_valid, 5);
    chk("rd_early", rdy_early, 0);
    chk("rd_err",   r_err, 0);
    chk("rd_raddr", r_addr, ADDR1);
    // column = {addr[17:12], addr[5:2]} = {6'h05, 4'hE}
    chk("rd_row",   a_cmd_row, 16'h048D);
    chk("rd_bg",    a_cmd_bg, 3'b100);
    chk("rd_bank",  a_cmd_bank, 2'b01);
    chk("rd_ch",    a_cmd_channel, 1);
    chk("rd_col",   a_cmd_col, 10'h05E);

    // Write: WR 40-41, PRE 86, response 125.
    run_req(1'b0, 2'd1, ADDR1);
    chk("wr_cas",  t_cas, 40);
    chk("wr_code", cas_code, 3);
    chk("wr_pre",  t_pre, 86);
    chk("wr_resp", t_resp, 125);
    chk("wr_rop",  r_op, 1);

    // Instruction fetch behaves as a read.
    run_req(1'b0, 2'd2, ADDR1);
    chk("if_code", cas_code, 2);
    chk("if_pre",  t_pre, 88);

    // TRAS=100: PRE held to 101 by tRAS, response 140.
    run_req(1'b1, 2'd0, ADDR1);
    chk("ras_cas",  t_cas, 40);
    chk("ras_pre",  t_pre, 101);
    chk("ras_resp", t_resp, 140);

    // Illegal op: immediate error response, no commands, fields untouched.
    run_req(1'b0, 2'd3, 34'h3_FFFF_FFFF);
    chk("ill_resp", t_resp, 1);
    chk("ill_err",  r_err, 1);
    chk("ill_op",   r_op, 3);
    chk("ill_nval", n_valid, 0);
    chk("ill_rdy",  t_rdy, 2);
    chk("ill_row",  a_cmd_row, 16'h048D);

    // Reset at cycle 50 of a read.
    sel = 1'b0; req_op = 2'd0; req_addr = ADDR1; req_valid_a = 1'b1; cyc = 0;
    step();
    req_valid_a = 1'b0;
    while (cyc < 50) step();
    chk("mid_busy", a_busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("mr_ready",  a_req_ready, 1);
    chk("mr_busy",   a_busy, 0);
    chk("mr_cvalid", a_cmd_valid, 0);
    chk("mr_row",    a_cmd_row, 0);
    #2 reset = 1'b0;
    run_req(1'b0, 2'd0, ADDR1);
    chk("pr_act",  t_act, 1);
    chk("pr_nval", n_valid, 5);
    chk("pr_resp", t_resp, 127);

    // Back-to-back with req_valid held: second accept at 128, its ACT at 129.
    sel = 1'b0; req_op = 2'd0; req_addr = ADDR1; req_valid_a = 1'b1; cyc = 0;
    t_resp = -1; t_act2 = -1; n_act = 0;
    step();
    req_addr = ADDR2;
    while (t_act2 < 0 && cyc < 400) begin
      if (a_cmd_valid && !a_cmd_phase && a_cmd_code == 3'd1) begin
        n_act++;
        if (t_resp >= 0) t_act2 = cyc;
      end
      if (a_resp_valid && t_resp < 0) t_resp = cyc;
      if (t_act2 < 0) step();
    end
    req_valid_a = 1'b0;
    chk("b2b_resp", t_resp, 127);
    chk("b2b_act2", t_act2, 129);
    chk("b2b_nact", n_act, 2);
    chk("b2b_row",  a_cmd_row, 16'h8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
